// File: rtl/exec_pkg.sv
// Shared types and instruction field positions for the register8 execute stage.
package exec_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned REG_AW  = 3;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 3;

    localparam int unsigned OP_LSB  = 13;
    localparam int unsigned RD_LSB  = 10;
    localparam int unsigned RS1_LSB = 7;
    localparam int unsigned RS2_LSB = 4;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_LDI  = 3'd6,
        OP_HALT = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // Ops that produce a register result (write still suppressed for rd=0).
    function automatic logic writes_reg(input opcode_t op);
        return (op != OP_NOP) && (op != OP_HALT);
    endfunction

    // Ops whose result drives the zero/carry flags.
    function automatic logic updates_flags(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/register8_exec_alu8.sv
// Purely combinational 8-bit ALU; LDI passes operand b through.
module alu8
    import exec_pkg::*;
(
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] result,
    output logic       carry
);

    logic [8:0] sum9;

    assign sum9 = {1'b0, a} + {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum9[7:0];
                carry  = sum9[8];
            end
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_LDI: result = b;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/register8_exec.sv
// Four-cycle execute/write-back stage: accept, read operands, execute, write back.
module register8_exec
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [2:0]  reg_addr_1,
    output logic [2:0]  reg_addr_2,
    input  logic [7:0]  reg_data_1,
    input  logic [7:0]  reg_data_2,
    output logic        write_enable,
    output logic [2:0]  write_addr,
    output logic [7:0]  write_data,
    output logic        flag_zero,
    output logic        flag_carry,
    output logic [7:0]  retired,
    output logic        halted
);

    state_t state_q, state_d;

    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  opa_q, opb_q;
    opcode_t            op;
    logic [REG_AW-1:0]  rd;
    logic [DATA_W-1:0]  imm8;
    logic [DATA_W-1:0]  alu_b;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_carry;
    logic               accept;

    assign op         = opcode_t'(instr_q[OP_LSB +: OP_W]);
    assign rd         = instr_q[RD_LSB +: REG_AW];
    assign imm8       = instr_q[IMM_LSB +: DATA_W];
    assign reg_addr_1 = instr_q[RS1_LSB +: REG_AW];
    assign reg_addr_2 = instr_q[RS2_LSB +: REG_AW];
    assign alu_b      = (op == OP_LDI) ? imm8 : opb_q;

    alu8 u_alu (
        .op     (instr_q[OP_LSB +: OP_W]),
        .a      (opa_q),
        .b      (alu_b),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    accept  = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ:   state_d = ST_EXEC;
            ST_EXEC:   state_d = (op == OP_HALT) ? ST_HALTED : ST_WB;
            ST_WB:     state_d = ST_IDLE;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath, write port, flags and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q      <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            instr_ready  <= 1'b1;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            flag_zero    <= 1'b0;
            flag_carry   <= 1'b0;
            retired      <= '0;
            halted       <= 1'b0;
        end else begin
            instr_ready <= (state_d == ST_IDLE);
            halted      <= (state_d == ST_HALTED);

            if (accept) instr_q <= instr;

            if (state_q == ST_READ) begin
                opa_q <= reg_data_1;
                opb_q <= reg_data_2;
            end

            if (state_q == ST_EXEC) begin
                write_addr   <= rd;
                write_data   <= alu_result;
                write_enable <= writes_reg(op) && (rd != '0);
                if (updates_flags(op)) begin
                    flag_zero  <= (alu_result == '0);
                    flag_carry <= alu_carry;
                end
                // HALT retires on entry to HALTED, it never reaches WB.
                if (op == OP_HALT) retired <= retired + 8'd1;
            end

            if (state_q == ST_WB) begin
                write_enable <= 1'b0;
                retired      <= retired + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_register8_exec.sv
// Directed bench for register8_exec with a two-edge-latency register bank model.
module tb_register8_exec;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [2:0]  reg_addr_1, reg_addr_2;
    logic [7:0]  reg_data_1, reg_data_2;
    logic        write_enable;
    logic [2:0]  write_addr;
    logic [7:0]  write_data;
    logic        flag_zero, flag_carry;
    logic [7:0]  retired;
    logic        halted;

    int checks;
    int failures;
    int we_count;

    logic [7:0] bank [8];
    logic       clr_bank;
    logic       pend_v;
    logic [2:0] pend_a;
    logic [7:0] pend_d;

    register8_exec dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .reg_addr_1   (reg_addr_1),
        .reg_addr_2   (reg_addr_2),
        .reg_data_1   (reg_data_1),
        .reg_data_2   (reg_data_2),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .flag_zero    (flag_zero),
        .flag_carry   (flag_carry),
        .retired      (retired),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank: a write becomes readable two edges after its strobe cycle.
    always @(posedge clk) begin
        if (clr_bank) begin
            for (int i = 0; i < 8; i++) bank[i] <= 8'h00;
            pend_v <= 1'b0;
        end else begin
            if (pend_v) bank[pend_a] <= pend_d;
            pend_v <= write_enable;
            pend_a <= write_addr;
            pend_d <= write_data;
        end
    end

    assign reg_data_1 = bank[reg_addr_1];
    assign reg_data_2 = bank[reg_addr_2];

    always @(posedge clk) if (write_enable === 1'b1) we_count <= we_count + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
        return {3'(op), 3'(rd), 3'(rs1), 3'(rs2), 4'h0};
    endfunction

    function automatic logic [15:0] enc_ldi(input int rd, input logic [7:0] imm);
        return {3'd6, 3'(rd), 2'b00, imm};
    endfunction

    // Issue one instruction from an IDLE negedge and walk its four cycles.
    task automatic run_instr(input string tag, input logic [15:0] w, input logic exp_we,
                             input logic [2:0] ea, input logic [7:0] ed);
        logic [2:0] rs1, rs2;
        rs1 = w[9:7];
        rs2 = w[6:4];
        check({tag, "_ready"}, 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr       = w;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        check({tag, "_c1_we"}, 32'(write_enable), 32'd0);
        check({tag, "_c1_ra1"}, 32'(reg_addr_1), 32'(rs1));
        check({tag, "_c1_ra2"}, 32'(reg_addr_2), 32'(rs2));
        @(negedge clk);
        check({tag, "_c2_we"}, 32'(write_enable), 32'd0);
        @(negedge clk);
        check({tag, "_c3_we"}, 32'(write_enable), 32'(exp_we));
        if (exp_we) begin
            check({tag, "_c3_addr"}, 32'(write_addr), 32'(ea));
            check({tag, "_c3_data"}, 32'(write_data), 32'(ed));
        end
        @(negedge clk);
        check({tag, "_c4_we"}, 32'(write_enable), 32'd0);
    endtask

    task automatic check_flags(input string tag, input logic z, input logic c, input int ret);
        check({tag, "_zero"}, 32'(flag_zero), 32'(z));
        check({tag, "_carry"}, 32'(flag_carry), 32'(c));
        check({tag, "_retired"}, 32'(retired), 32'(ret));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(instr_ready), 32'd1);
        check({tag, "_we"}, 32'(write_enable), 32'd0);
        check({tag, "_waddr"}, 32'(write_addr), 32'd0);
        check({tag, "_wdata"}, 32'(write_data), 32'd0);
        check({tag, "_ra1"}, 32'(reg_addr_1), 32'd0);
        check({tag, "_ra2"}, 32'(reg_addr_2), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check_flags(tag, 1'b0, 1'b0, 0);
    endtask

    initial begin
        int we_base;
        checks      = 0;
        failures    = 0;
        we_count    = 0;
        rst         = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        clr_bank    = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst0");
        rst      = 1'b1;
        clr_bank = 1'b0;
        @(negedge clk);

        run_instr("ldi_r1_2a", enc_ldi(1, 8'h2A), 1'b1, 3'd1, 8'h2A);
        check_flags("ldi_r1_2a", 1'b0, 1'b0, 1);

        run_instr("ldi_r1_f0", enc_ldi(1, 8'hF0), 1'b1, 3'd1, 8'hF0);
        run_instr("ldi_r2_20", enc_ldi(2, 8'h20), 1'b1, 3'd2, 8'h20);
        run_instr("add_r3", enc_r(1, 3, 1, 2), 1'b1, 3'd3, 8'h10);
        check_flags("add_r3", 1'b0, 1'b1, 4);

        run_instr("sub_r4", enc_r(2, 4, 2, 1), 1'b1, 3'd4, 8'h30);
        check_flags("sub_r4", 1'b0, 1'b1, 5);
        run_instr("sub_r5", enc_r(2, 5, 1, 1), 1'b1, 3'd5, 8'h00);
        check_flags("sub_r5", 1'b1, 1'b0, 6);

        run_instr("add_r0", enc_r(1, 0, 1, 2), 1'b0, 3'd0, 8'h00);
        check_flags("add_r0", 1'b0, 1'b1, 7);

        run_instr("nop", enc_r(0, 6, 1, 2), 1'b0, 3'd0, 8'h00);
        check_flags("nop", 1'b0, 1'b1, 8);
        run_instr("and_r6", enc_r(3, 6, 1, 2), 1'b1, 3'd6, 8'h20);
        check_flags("and_r6", 1'b0, 1'b0, 9);
        run_instr("or_r6", enc_r(4, 6, 1, 2), 1'b1, 3'd6, 8'hF0);
        check_flags("or_r6", 1'b0, 1'b0, 10);
        run_instr("xor_r7", enc_r(5, 7, 2, 2), 1'b1, 3'd7, 8'h00);
        check_flags("xor_r7", 1'b1, 1'b0, 11);
        run_instr("ldi_r5_00", enc_ldi(5, 8'h00), 1'b1, 3'd5, 8'h00);
        check_flags("ldi_r5_00", 1'b1, 1'b0, 12);

        @(negedge clk);
        check("bank_r1", 32'(bank[1]), 32'hF0);
        check("bank_r2", 32'(bank[2]), 32'h20);
        check("bank_r3", 32'(bank[3]), 32'h10);
        check("bank_r4", 32'(bank[4]), 32'h30);
        check("bank_r6", 32'(bank[6]), 32'hF0);
        check("bank_r0", 32'(bank[0]), 32'h00);

        // HALT, then a held request must be ignored.
        instr_valid = 1'b1;
        instr       = 16'hE000;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_ready", 32'(instr_ready), 32'd0);
        check("halt_retired", 32'(retired), 32'd13);
        we_base     = we_count;
        instr_valid = 1'b1;
        instr       = enc_ldi(1, 8'h77);
        repeat (10) @(negedge clk);
        check("halt_hold_we", 32'(we_count), 32'(we_base));
        check("halt_hold_retired", 32'(retired), 32'd13);
        check("halt_hold_ready", 32'(instr_ready), 32'd0);
        check("halt_hold_halted", 32'(halted), 32'd1);
        instr_valid = 1'b0;

        rst = 1'b0;
        #1 check_reset_outputs("rst_halt");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset mid-EXEC of LDI r7,0x55.
        instr_valid = 1'b1;
        instr       = enc_ldi(7, 8'h55);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        we_base = we_count;
        rst     = 1'b0;
        #1 check_reset_outputs("rst_exec");
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_exec_no_we", 32'(we_count), 32'(we_base));
        check("rst_exec_retired", 32'(retired), 32'd0);
        check("rst_exec_ready", 32'(instr_ready), 32'd1);
        check("rst_exec_bank_r7", 32'(bank[7]), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
